// File: rtl/ippro_stream_fifo_pkg.sv
// Shared constants and flag helpers for the IPPro inter-core stream FIFO.
// The optional high-water-mark feature is enabled by IPPRO_FIFO_HWM_EN.
package ippro_stream_fifo_pkg;

    localparam int FIFO_DATASIZE     = 32;
    localparam int FIFO_DEPTH        = 32;
    localparam int FIFO_AFULL_MARGIN = 4;

    typedef struct packed {
        logic empty;
        logic full;
        logic afull;
    } fifo_flags_t;

    function automatic fifo_flags_t flags_from_count(input int count,
                                                     input int depth,
                                                     input int afull_th);
        fifo_flags_t f;
        f.empty = (count == 0);
        f.full  = (count == depth);
        f.afull = (count >= afull_th);
        return f;
    endfunction

endpackage

// File: rtl/ippro_fifo_ram.sv
// Simple dual-port DEPTH x DATA_W storage: synchronous write, registered read.
// Only the read register is reset/cleared; the array itself keeps its contents.
module ippro_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CLR,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic                     i_re,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic signed [DATA_W-1:0] o_rdata
);

    logic signed [DATA_W-1:0] r_mem [DEPTH];
    logic signed [DATA_W-1:0] r_rdata;

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register holds its value between pops.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rdata <= '0;
        end else if (CLR) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ippro_stream_fifo.sv
// Single-clock stream FIFO between IPPro cores with registered flags and sticky errors.
// Define IPPRO_FIFO_HWM_EN to add the HWM output and HWM_CLR input.
module ippro_stream_fifo
    import ippro_stream_fifo_pkg::*;
#(
    parameter  int DATA_W   = FIFO_DATASIZE,
    parameter  int DEPTH    = FIFO_DEPTH,
    parameter  int AFULL_TH = DEPTH - FIFO_AFULL_MARGIN,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CLR,
    input  logic                     WR_EN,
    input  logic signed [DATA_W-1:0] WR_DATA,
    output logic                     FULL,
    output logic                     AFULL,
    input  logic                     RD_EN,
    output logic signed [DATA_W-1:0] RD_DATA,
    output logic                     RD_VALID,
    output logic                     EMPTY,
    output logic [ADDR_W:0]          COUNT,
    output logic                     OVF,
    output logic                     UDF
`ifdef IPPRO_FIFO_HWM_EN
   ,input  logic                     HWM_CLR,
    output logic [ADDR_W:0]          HWM
`endif
);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_udf;

    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic [ADDR_W:0]   w_count_nxt;
    fifo_flags_t       w_flags_nxt;

    // Acceptance uses only registered flags, so a same-cycle pop never frees room for a push.
    always_comb begin
        w_push      = WR_EN & ~r_full  & ~CLR;
        w_pop       = RD_EN & ~r_empty & ~CLR;
        w_ovf_evt   = WR_EN &  r_full  & ~CLR;
        w_udf_evt   = RD_EN &  r_empty & ~CLR;
        w_count_nxt = '0;
        if (!CLR) begin
            w_count_nxt = r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
        end
        w_flags_nxt = flags_from_count(int'(w_count_nxt), DEPTH, AFULL_TH);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_empty    <= w_flags_nxt.empty;
            r_full     <= w_flags_nxt.full;
            r_afull    <= w_flags_nxt.afull;
            r_rd_valid <= w_pop;
            if (CLR) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ovf  <= 1'b0;
                r_udf  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_ovf <= r_ovf | w_ovf_evt;
                r_udf <= r_udf | w_udf_evt;
            end
        end
    end

    ippro_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK     (CLK),
        .RESET   (RESET),
        .CLR     (CLR),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (WR_DATA),
        .i_re    (w_pop),
        .i_raddr (r_rptr),
        .o_rdata (RD_DATA)
    );

`ifdef IPPRO_FIFO_HWM_EN
    logic [ADDR_W:0] r_hwm;

    // CLR drives next count to zero, so the max naturally retains the mark.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hwm <= '0;
        end else if (HWM_CLR) begin
            r_hwm <= '0;
        end else if (w_count_nxt > r_hwm) begin
            r_hwm <= w_count_nxt;
        end
    end

    assign HWM = r_hwm;
`endif

    assign COUNT    = r_count;
    assign EMPTY    = r_empty;
    assign FULL     = r_full;
    assign AFULL    = r_afull;
    assign RD_VALID = r_rd_valid;
    assign OVF      = r_ovf;
    assign UDF      = r_udf;

endmodule

// File: tb/tb_ippro_stream_fifo.sv
// Self-checking bench for ippro_stream_fifo against a queue-based reference model.
// Define IPPRO_FIFO_HWM_EN to also exercise the high-water mark.
module tb_ippro_stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int AFTH  = 28;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic                 CLR;
    logic                 WR_EN;
    logic signed [DW-1:0] WR_DATA;
    logic                 FULL;
    logic                 AFULL;
    logic                 RD_EN;
    logic signed [DW-1:0] RD_DATA;
    logic                 RD_VALID;
    logic                 EMPTY;
    logic [AW:0]          COUNT;
    logic                 OVF;
    logic                 UDF;
`ifdef IPPRO_FIFO_HWM_EN
    logic                 HWM_CLR;
    logic [AW:0]          HWM;
`endif

    always #5 CLK = ~CLK;

    ippro_stream_fifo #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFTH)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CLR      (CLR),
        .WR_EN    (WR_EN),
        .WR_DATA  (WR_DATA),
        .FULL     (FULL),
        .AFULL    (AFULL),
        .RD_EN    (RD_EN),
        .RD_DATA  (RD_DATA),
        .RD_VALID (RD_VALID),
        .EMPTY    (EMPTY),
        .COUNT    (COUNT),
        .OVF      (OVF),
        .UDF      (UDF)
`ifdef IPPRO_FIFO_HWM_EN
       ,.HWM_CLR  (HWM_CLR),
        .HWM      (HWM)
`endif
    );

    // Reference model: contents as a queue, plus the observable side state.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rdata;
    bit            m_rdv;
    bit            m_ovf;
    bit            m_udf;
    int            m_hwm;

    int n_cmp;
    int n_err;

    task automatic model_reset();
        m_q.delete();
        m_rdata = '0;
        m_rdv   = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_hwm   = 0;
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, settle.
    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr);
        bit pop_ok;
        bit push_ok;
        @(negedge CLK);
        WR_EN   = wr;
        WR_DATA = wd;
        RD_EN   = rd;
        CLR     = clr;
        @(posedge CLK);
        if (clr) begin
            m_q.delete();
            m_rdata = '0;
            m_rdv   = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            pop_ok  = rd && (m_q.size() > 0);
            push_ok = wr && (m_q.size() < DEPTH);
            m_rdv   = pop_ok;
            if (pop_ok)  m_rdata = m_q.pop_front();
            if (push_ok) m_q.push_back(wd);
            if (wr && !push_ok) m_ovf = 1'b1;
            if (rd && !pop_ok)  m_udf = 1'b1;
        end
        if (m_q.size() > m_hwm) m_hwm = m_q.size();
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        n_cmp += 5;
        if (COUNT !== 6'd0)      begin n_err++; $display("FAIL reset_count got %0d want 0", COUNT); end
        if (EMPTY !== 1'b1)      begin n_err++; $display("FAIL reset_empty got %0b want 1", EMPTY); end
        if ({FULL, AFULL} !== 2'b00) begin n_err++; $display("FAIL reset_full_afull got %b want 00", {FULL, AFULL}); end
        if (RD_DATA !== 32'd0)   begin n_err++; $display("FAIL reset_rd_data got %h want 0", RD_DATA); end
        if ({RD_VALID, OVF, UDF} !== 3'b000) begin n_err++; $display("FAIL reset_vld_ovf_udf got %b want 000", {RD_VALID, OVF, UDF}); end
        @(negedge CLK);
        RESET = 1'b1;

        // Build up state mid-stream, then pull RESET asynchronously.
        step(0, '0, 1, 0);
        for (int i = 1; i <= 6; i++) step(1, 32'(i), 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'hFF, 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        n_cmp += 3;
        if (COUNT !== 6'd5)   begin n_err++; $display("FAIL pre_reset_count got %0d want 5", COUNT); end
        if (UDF !== 1'b1)     begin n_err++; $display("FAIL pre_reset_udf got %0b want 1", UDF); end
        if (RD_VALID !== 1'b1) begin n_err++; $display("FAIL pre_reset_rd_valid got %0b want 1", RD_VALID); end
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        n_cmp += 4;
        if (COUNT !== 6'd0)    begin n_err++; $display("FAIL async_reset_count got %0d want 0", COUNT); end
        if (EMPTY !== 1'b1)    begin n_err++; $display("FAIL async_reset_empty got %0b want 1", EMPTY); end
        if (RD_VALID !== 1'b0) begin n_err++; $display("FAIL async_reset_rd_valid got %0b want 0", RD_VALID); end
        if ({OVF, UDF} !== 2'b00) begin n_err++; $display("FAIL async_reset_ovf_udf got %b want 00", {OVF, UDF}); end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_fill();
        step(0, '0, 0, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 32'(i), 0, 0);
            n_cmp += 4;
            if (COUNT !== 6'(i))               begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, COUNT, i); end
            if (AFULL !== (i >= AFTH))         begin n_err++; $display("FAIL fill_afull[%0d] got %0b want %0b", i, AFULL, i >= AFTH); end
            if (FULL !== (i == DEPTH))         begin n_err++; $display("FAIL fill_full[%0d] got %0b want %0b", i, FULL, i == DEPTH); end
            if (EMPTY !== 1'b0)                begin n_err++; $display("FAIL fill_empty[%0d] got %0b want 0", i, EMPTY); end
        end
        step(1, 32'h21, 0, 0);
        n_cmp += 3;
        if (COUNT !== 6'd32) begin n_err++; $display("FAIL overflow_count got %0d want 32", COUNT); end
        if (OVF !== 1'b1)    begin n_err++; $display("FAIL overflow_ovf got %0b want 1", OVF); end
        if (FULL !== 1'b1)   begin n_err++; $display("FAIL overflow_full got %0b want 1", FULL); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, '0, 1, 0);
            n_cmp += 4;
            if (RD_VALID !== 1'b1)          begin n_err++; $display("FAIL drain_valid[%0d] got %0b want 1", i, RD_VALID); end
            if (RD_DATA !== 32'(i))         begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, RD_DATA, 32'(i)); end
            if (COUNT !== 6'(DEPTH - i))    begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, COUNT, DEPTH - i); end
            if (EMPTY !== (i == DEPTH))     begin n_err++; $display("FAIL drain_empty[%0d] got %0b want %0b", i, EMPTY, i == DEPTH); end
        end
        step(0, '0, 1, 0);
        n_cmp += 3;
        if (UDF !== 1'b1)       begin n_err++; $display("FAIL underflow_udf got %0b want 1", UDF); end
        if (RD_VALID !== 1'b0)  begin n_err++; $display("FAIL underflow_valid got %0b want 0", RD_VALID); end
        if (RD_DATA !== 32'h20) begin n_err++; $display("FAIL underflow_hold got %h want 00000020", RD_DATA); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] wd;
        int            k;
        step(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            wd = $urandom;
            sent.push_back(wd);
            step(1, wd, 0, 0);
        end
        k = 0;
        for (int c = 0; c < 100; c++) begin
            wd = $urandom;
            sent.push_back(wd);
            step(1, wd, 1, 0);
            n_cmp += 3;
            if (COUNT !== 6'd3)      begin n_err++; $display("FAIL b2b_count[%0d] got %0d want 3", c, COUNT); end
            if (RD_VALID !== 1'b1)   begin n_err++; $display("FAIL b2b_valid[%0d] got %0b want 1", c, RD_VALID); end
            if (RD_DATA !== sent[k]) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", c, RD_DATA, sent[k]); end
            k++;
        end
        n_cmp++;
        if (OVF | UDF) begin n_err++; $display("FAIL b2b_errors got ovf=%0b udf=%0b want 0 0", OVF, UDF); end
    endtask

    task automatic test_push_pop_empty();
        step(0, '0, 0, 1);
        step(1, 32'hDEADBEEF, 1, 0);
        n_cmp += 3;
        if (COUNT !== 6'd1)    begin n_err++; $display("FAIL pp_empty_count got %0d want 1", COUNT); end
        if (UDF !== 1'b1)      begin n_err++; $display("FAIL pp_empty_udf got %0b want 1", UDF); end
        if (RD_VALID !== 1'b0) begin n_err++; $display("FAIL pp_empty_valid got %0b want 0", RD_VALID); end
        step(0, '0, 1, 0);
        n_cmp += 3;
        if (RD_VALID !== 1'b1)        begin n_err++; $display("FAIL pp_next_valid got %0b want 1", RD_VALID); end
        if (RD_DATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL pp_next_data got %h want deadbeef", RD_DATA); end
        if (EMPTY !== 1'b1)           begin n_err++; $display("FAIL pp_next_empty got %0b want 1", EMPTY); end
    endtask

    task automatic test_random();
        bit wr;
        bit rd;
        bit clr;
        int wprob;
        step(0, '0, 0, 1);
        for (int c = 0; c < 600; c++) begin
            wprob = ((c / 60) % 2 == 0) ? 80 : 20;
            wr  = ($urandom_range(0, 99) < wprob);
            rd  = ($urandom_range(0, 99) < (100 - wprob));
            clr = ($urandom_range(0, 149) == 0);
            step(wr, $urandom, rd, clr);
            n_cmp += 8;
            if (COUNT !== 6'(m_q.size()))           begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, COUNT, m_q.size()); end
            if (EMPTY !== (m_q.size() == 0))        begin n_err++; $display("FAIL rnd_empty[%0d] got %0b want %0b", c, EMPTY, m_q.size() == 0); end
            if (FULL !== (m_q.size() == DEPTH))     begin n_err++; $display("FAIL rnd_full[%0d] got %0b want %0b", c, FULL, m_q.size() == DEPTH); end
            if (AFULL !== (m_q.size() >= AFTH))     begin n_err++; $display("FAIL rnd_afull[%0d] got %0b want %0b", c, AFULL, m_q.size() >= AFTH); end
            if (RD_VALID !== m_rdv)                 begin n_err++; $display("FAIL rnd_valid[%0d] got %0b want %0b", c, RD_VALID, m_rdv); end
            if (RD_DATA !== m_rdata)                begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", c, RD_DATA, m_rdata); end
            if (OVF !== m_ovf)                      begin n_err++; $display("FAIL rnd_ovf[%0d] got %0b want %0b", c, OVF, m_ovf); end
            if (UDF !== m_udf)                      begin n_err++; $display("FAIL rnd_udf[%0d] got %0b want %0b", c, UDF, m_udf); end
`ifdef IPPRO_FIFO_HWM_EN
            n_cmp++;
            if (HWM !== 6'(m_hwm))                  begin n_err++; $display("FAIL rnd_hwm[%0d] got %0d want %0d", c, HWM, m_hwm); end
`endif
        end
    endtask

`ifdef IPPRO_FIFO_HWM_EN
    task automatic test_hwm();
        step(0, '0, 0, 1);
        @(negedge CLK);
        WR_EN = 1'b0; RD_EN = 1'b0; CLR = 1'b0; HWM_CLR = 1'b1;
        @(posedge CLK);
        #1;
        m_hwm = 0;
        n_cmp++;
        if (HWM !== 6'd0) begin n_err++; $display("FAIL hwm_start got %0d want 0", HWM); end
        @(negedge CLK);
        HWM_CLR = 1'b0;
        for (int i = 0; i < 17; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 17; i++) step(0, '0, 1, 0);
        n_cmp += 2;
        if (HWM !== 6'd17)  begin n_err++; $display("FAIL hwm_drained got %0d want 17", HWM); end
        if (COUNT !== 6'd0) begin n_err++; $display("FAIL hwm_count got %0d want 0", COUNT); end
        step(0, '0, 0, 1);
        n_cmp++;
        if (HWM !== 6'd17) begin n_err++; $display("FAIL hwm_after_clr got %0d want 17", HWM); end
        @(negedge CLK);
        WR_EN = 1'b0; RD_EN = 1'b0; CLR = 1'b0; HWM_CLR = 1'b1;
        @(posedge CLK);
        #1;
        m_hwm = 0;
        n_cmp++;
        if (HWM !== 6'd0) begin n_err++; $display("FAIL hwm_clr got %0d want 0", HWM); end
        @(negedge CLK);
        HWM_CLR = 1'b0;
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        CLR     = 1'b0;
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        WR_DATA = '0;
`ifdef IPPRO_FIFO_HWM_EN
        HWM_CLR = 1'b0;
`endif
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_push_pop_empty();
`ifdef IPPRO_FIFO_HWM_EN
        test_hwm();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
